// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D to slow_memory port arbiter:
// FSM state encoding, side identifiers and default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  // A side is requesting when either of its strobes is high
  function automatic logic req_of(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick. When both sides request, the side that was not
// served last wins; a lone requester always wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_side
);

  // Pick the winning side from the two requests and the last-served side
  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_side  = SIDE_I;
    if (req_i && req_d) begin
      gnt_side = ~last;
    end else if (req_d) begin
      gnt_side = SIDE_D;
    end else begin
      gnt_side = SIDE_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-cache and D-cache miss ports onto one slow_memory port.
// One transaction at a time: IDLE picks a side, GRANT holds the memory request
// until mem_ready, RESP gives the winner a one-cycle ready pulse. All outputs
// come straight from registers. Saturating counters track grants and bus use.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit CHECK_RW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  cnt_i_grant,
  output logic [CNT_W-1:0]  cnt_d_grant,
  output logic [CNT_W-1:0]  cnt_busy
);

  arb_state_e        state_r, next_state_s;
  logic              rr_last_r;
  logic              gnt_side_r;
  logic              req_i_s, req_d_s;
  logic              gnt_valid_s, gnt_side_s;

  logic              mem_read_r, mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              i_ready_r, d_ready_r;
  logic [DATA_W-1:0] i_rdata_r, d_rdata_r;
  logic [CNT_W-1:0]  cnt_i_r, cnt_d_r, cnt_busy_r;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign req_i_s = req_of(i_read, i_write);
  assign req_d_s = req_of(d_read, d_write);

  rr_arb2 u_rr_arb2 (
    .req_i     (req_i_s),
    .req_d     (req_d_s),
    .last      (rr_last_r),
    .gnt_valid (gnt_valid_s),
    .gnt_side  (gnt_side_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: IDLE -> GRANT on any request, GRANT -> RESP on mem_ready,
  // RESP always back to IDLE so a held request is re-sampled fresh
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          next_state_s = GRANT;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT: begin
        if (mem_ready) begin
          next_state_s = RESP;
        end else begin
          next_state_s = GRANT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latching, memory strobes, response capture and ready pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_r   <= SIDE_I;
      gnt_side_r  <= SIDE_I;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      i_ready_r   <= 1'b0;
      d_ready_r   <= 1'b0;
      i_rdata_r   <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          i_ready_r <= 1'b0;
          d_ready_r <= 1'b0;
          if (gnt_valid_s) begin
            gnt_side_r <= gnt_side_s;
            rr_last_r  <= gnt_side_s;
            if (gnt_side_s == SIDE_D) begin
              mem_addr_r  <= d_addr;
              mem_wdata_r <= d_wdata;
              mem_write_r <= d_write;
              mem_read_r  <= d_read & ~d_write;
            end else begin
              mem_addr_r  <= i_addr;
              mem_wdata_r <= i_wdata;
              mem_write_r <= i_write;
              mem_read_r  <= i_read & ~i_write;
            end
          end
        end
        GRANT: begin
          if (mem_ready) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            if (gnt_side_r == SIDE_D) begin
              d_ready_r <= 1'b1;
              d_rdata_r <= mem_write_r ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
              i_ready_r <= 1'b1;
              i_rdata_r <= mem_write_r ? {DATA_W{1'b0}} : mem_rdata;
            end
          end
        end
        RESP: begin
          i_ready_r <= 1'b0;
          d_ready_r <= 1'b0;
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          i_ready_r   <= 1'b0;
          d_ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Grant counters bump in RESP; busy counter bumps on every strobed cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_i_r    <= {CNT_W{1'b0}};
      cnt_d_r    <= {CNT_W{1'b0}};
      cnt_busy_r <= {CNT_W{1'b0}};
    end else begin
      if (state_r == RESP) begin
        if (gnt_side_r == SIDE_D) begin
          cnt_d_r <= sat_inc(cnt_d_r);
        end else begin
          cnt_i_r <= sat_inc(cnt_i_r);
        end
      end
      if (mem_read_r | mem_write_r) begin
        cnt_busy_r <= sat_inc(cnt_busy_r);
      end
    end
  end

  // Simulation warning when a side strobes read and write together at grant
  always_ff @(posedge clk) begin
    if (CHECK_RW && rst_n && (state_r == IDLE) && gnt_valid_s) begin
      if ((gnt_side_s == SIDE_I) && i_read && i_write) begin
        $error("mem_port_arbiter: I side read+write together, serviced as write");
      end else if ((gnt_side_s == SIDE_D) && d_read && d_write) begin
        $error("mem_port_arbiter: D side read+write together, serviced as write");
      end
    end
  end

  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign i_ready     = i_ready_r;
  assign d_ready     = d_ready_r;
  assign i_rdata     = i_rdata_r;
  assign d_rdata     = d_rdata_r;
  assign cnt_i_grant = cnt_i_r;
  assign cnt_d_grant = cnt_d_r;
  assign cnt_busy    = cnt_busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single and paired
// transactions, plus hand sequences for held requests, mid-grant reset and
// busy-counter saturation. Inputs change and outputs are sampled on negedges.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] cnt_i_grant, cnt_d_grant, cnt_busy;

  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] m_i, m_d, m_busy;

  always #5 clk = ~clk;

  // The read+write warning is off here so the write-priority vector runs clean
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .CHECK_RW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_busy(cnt_busy)
  );

  typedef struct {
    logic          i_rd, i_wr;
    logic [AW-1:0] i_ad;
    logic [DW-1:0] i_wd;
    logic          d_rd, d_wr;
    logic [AW-1:0] d_ad;
    logic [DW-1:0] d_wd;
    logic          first;
    logic          i_wr_exp, d_wr_exp;
    int            nserve;
    logic [DW-1:0] rdata;
    int            lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] v, input int n);
    logic [CW-1:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      if (r != {CW{1'b1}}) r = r + 32'd1;
    end
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "/mem_read"},  DW'(mem_read),  DW'(0));
    check({tag, "/mem_write"}, DW'(mem_write), DW'(0));
    check({tag, "/i_ready"},   DW'(i_ready),   DW'(0));
    check({tag, "/d_ready"},   DW'(d_ready),   DW'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check({tag, "/mem_addr"},  DW'(mem_addr),    DW'(0));
    check({tag, "/mem_wdata"}, mem_wdata,        DW'(0));
    check({tag, "/i_rdata"},   i_rdata,          DW'(0));
    check({tag, "/d_rdata"},   d_rdata,          DW'(0));
    check({tag, "/cnt_i"},     DW'(cnt_i_grant), DW'(0));
    check({tag, "/cnt_d"},     DW'(cnt_d_grant), DW'(0));
    check({tag, "/cnt_busy"},  DW'(cnt_busy),    DW'(0));
  endtask

  // One transaction: wait for the memory strobe, check it, answer after lat
  // extra cycles, check the ready pulse, then check the IDLE cycle after RESP.
  task automatic serve(input string tag, input logic side, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] rdata, input int lat, input bit drop);
    int            n;
    logic [DW-1:0] exp_line;
    n = 0;
    @(negedge clk);
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/req_latency"}, DW'(n), DW'(0));
    if (!(mem_read || mem_write)) return;
    check({tag, "/mem_read"},  DW'(mem_read),  DW'(!wr));
    check({tag, "/mem_write"}, DW'(mem_write), DW'(wr));
    check({tag, "/mem_addr"},  DW'(mem_addr),  DW'(addr));
    check({tag, "/mem_wdata"}, mem_wdata,      wdata);
    repeat (lat) @(negedge clk);
    mem_rdata = rdata;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = ~rdata;
    exp_line  = wr ? {DW{1'b0}} : rdata;
    check({tag, "/i_ready"}, DW'(i_ready), DW'(side == SIDE_I));
    check({tag, "/d_ready"}, DW'(d_ready), DW'(side == SIDE_D));
    if (side == SIDE_I) check({tag, "/i_rdata"}, i_rdata, exp_line);
    else                check({tag, "/d_rdata"}, d_rdata, exp_line);
    check({tag, "/strobe_drop"}, DW'(mem_read | mem_write), DW'(0));
    if (drop) begin
      if (side == SIDE_I) begin i_read = 1'b0; i_write = 1'b0; end
      else                begin d_read = 1'b0; d_write = 1'b0; end
    end
    if (side == SIDE_I) m_i = sat_add(m_i, 1);
    else                m_d = sat_add(m_d, 1);
    m_busy = sat_add(m_busy, lat + 1);
    @(negedge clk);
    check_quiet({tag, "/idle"});
    if (side == SIDE_I) check({tag, "/i_rdata_hold"}, i_rdata, exp_line);
    else                check({tag, "/d_rdata_hold"}, d_rdata, exp_line);
    check({tag, "/cnt_i"},    DW'(cnt_i_grant), DW'(m_i));
    check({tag, "/cnt_d"},    DW'(cnt_d_grant), DW'(m_d));
    check({tag, "/cnt_busy"}, DW'(cnt_busy),    DW'(m_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // i_ad i_wd / d_ad d_wd / first / exp write I,D / nserve / rdata / lat
    vecs[0] = '{1'b1, 1'b0, 28'h0000010, 128'h0, 1'b0, 1'b0, 28'h0, 128'h0,
                SIDE_I, 1'b0, 1'b0, 1, {16{8'hA5}}, 2};
    vecs[1] = '{1'b1, 1'b0, 28'h0000020, 128'h0, 1'b0, 1'b1, 28'h0000300, {4{32'hDEADBEEF}},
                SIDE_D, 1'b0, 1'b1, 2, {4{32'h11112222}}, 1};
    vecs[2] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b0, 28'h0000400, 128'h0,
                SIDE_D, 1'b0, 1'b0, 1, {4{32'h33334444}}, 0};
    vecs[3] = '{1'b0, 1'b1, 28'h0000500, {4{32'hCAFEF00D}}, 1'b1, 1'b0, 28'h0000600, 128'h0,
                SIDE_I, 1'b1, 1'b0, 2, {4{32'h55556666}}, 3};
    vecs[4] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b1, 28'h0000700, {4{32'h0BADCAFE}},
                SIDE_D, 1'b0, 1'b1, 1, {4{32'h77778888}}, 0};
    vecs[5] = '{1'b1, 1'b0, 28'hFFFFFFF, 128'h0, 1'b0, 1'b0, 28'h0, 128'h0,
                SIDE_I, 1'b0, 1'b0, 1, {DW{1'b1}}, 0};

    rst_n = 1'b0; i_read = 1'b1; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = 28'h0000123; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    m_i = '0; m_d = '0; m_busy = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    i_read = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // Table of single and paired transactions
    for (int v = 0; v < 6; v++) begin
      i_read = vecs[v].i_rd; i_write = vecs[v].i_wr; i_addr = vecs[v].i_ad; i_wdata = vecs[v].i_wd;
      d_read = vecs[v].d_rd; d_write = vecs[v].d_wr; d_addr = vecs[v].d_ad; d_wdata = vecs[v].d_wd;
      for (int k = 0; k < vecs[v].nserve; k++) begin
        logic s;
        s = (k == 0) ? vecs[v].first : ~vecs[v].first;
        if (s == SIDE_I)
          serve($sformatf("vec%0d.%0d", v, k), s, vecs[v].i_wr_exp, vecs[v].i_ad, vecs[v].i_wd,
                (k == 0) ? vecs[v].rdata : ~vecs[v].rdata, vecs[v].lat, 1'b1);
        else
          serve($sformatf("vec%0d.%0d", v, k), s, vecs[v].d_wr_exp, vecs[v].d_ad, vecs[v].d_wd,
                (k == 0) ? vecs[v].rdata : ~vecs[v].rdata, vecs[v].lat, 1'b1);
      end
    end

    // D holds its read across three transactions; dropped on the third pulse
    d_read = 1'b1; d_addr = 28'h0000800; d_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      serve($sformatf("held%0d", k), SIDE_D, 1'b0, 28'h0000800, 128'h0,
            {4{32'h0000A000 + 32'(k)}}, 1, k == 2);
    end
    repeat (3) begin
      @(negedge clk);
      check_quiet("held_no_regrant");
    end

    // Reset while GRANT holds mem_read, then a late mem_ready
    i_read = 1'b1; i_addr = 28'h0000900;
    @(negedge clk);
    check("rst_mid/mem_read_before", DW'(mem_read), DW'(1));
    rst_n = 1'b0; i_read = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    m_i = '0; m_d = '0; m_busy = '0;
    rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = {4{32'h99999999}};
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) begin
      check_quiet("late_ready");
      @(negedge clk);
    end

    // Busy counter forced to all-ones; a tie also shows rr_last was reset to I
    force dut.cnt_busy_r = {CW{1'b1}};
    #1;
    release dut.cnt_busy_r;
    m_busy = {CW{1'b1}};
    check("sat/preload", DW'(cnt_busy), DW'({CW{1'b1}}));
    @(negedge clk);
    i_read = 1'b1; i_addr = 28'h0000A10; d_read = 1'b1; d_addr = 28'h0000B20;
    serve("sat.0", SIDE_D, 1'b0, 28'h0000B20, 128'h0, {4{32'h12345678}}, 1, 1'b1);
    serve("sat.1", SIDE_I, 1'b0, 28'h0000A10, 128'h0, {4{32'h9ABCDEF0}}, 0, 1'b1);
    check("sat/final", DW'(cnt_busy), DW'({CW{1'b1}}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
